microwave_ctrl: RTL
===================

Name: microwave_ctrl

Overview:
- Top-level sequencer for the microwave timer datapath.
- Collects keypad digits into an MM:SS entry and normalises it before loading.
- Issues single-cycle start/stop/pause commands to the timer and reacts to door state and timer completion.
- Drives magnetron, lamp and buzzer. Sits between the board inputs (edge-detected keys/buttons, door switch) and the timer block.

Parameters:
- BEEP_CYCLES, 300_000_000: buzzer duration in clock cycles (3 s at 100 MHz).
- BEEP_W, 29: width of the beep counter; must hold BEEP_CYCLES.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- key_valid  input  1  single-cycle strobe, key_digit valid
- key_digit  input  4  keypad value; 0-9 accepted, 10-15 ignored
- btn_start  input  1  single-cycle pulse
- btn_stop  input  1  single-cycle pulse
- btn_add30  input  1  single-cycle pulse, quick +30 s
- door_open  input  1  level, already synchronised
- timer_done  input  1  level from timer, high when countdown reached 00:00
- min  output  7  minutes to timer, 0-99
- sec  output  7  seconds to timer, 0-59 when loaded
- t_start  output  1  one-cycle command pulse to timer
- t_stop  output  1  one-cycle command pulse to timer
- t_pause  output  1  one-cycle command pulse to timer
- magnetron_on  output  1  high only in RUN
- lamp_on  output  1  high in RUN, PAUSED, or whenever door_open=1
- buzzer  output  1  high in BEEP

Behaviour:
- Reset (async, active-high):
  - State=IDLE; entry digits d3..d0=0; min=0, sec=0.
  - t_start=t_stop=t_pause=0, magnetron_on=0, buzzer=0, beep counter=0.
  - lamp_on follows door_open combinationally even in reset.
- All command and status outputs are registered. A command pulse is asserted the cycle after the triggering input and lasts exactly 1 cycle.
- Entry:
  - On key_valid with digit<=9 in IDLE/ENTRY, shift left: d3<=d2, d2<=d1, d1<=d0, d0<=digit; state->ENTRY.
  - The fifth digit discards the oldest. Digits >9 are ignored. key_valid in RUN/PAUSED/BEEP is ignored.
- Raw value: rmin=d3*10+d2, rsec=d1*10+d0. In IDLE/ENTRY, min/sec show rmin/rsec.
- Normalisation:
  - If rsec>59: sec=rsec-60, min=rmin+1.
  - If the result exceeds 99:59, saturate to 99:59.
- States are IDLE, ENTRY, RUN, PAUSED, BEEP.
- IDLE/ENTRY:
  - btn_start with door closed and raw value non-zero: register normalised min/sec, pulse t_start, ->RUN.
  - btn_start with a zero value or door open: ignored.
  - btn_add30: entry = normalised(entry)+30 s with carry, saturate 99:59, written back into the digits.
    - If the door is closed and IDLE had an empty (zero) entry, also start immediately (00:30).
  - btn_stop: clear digits, ->IDLE.
- RUN:
  - door_open rising or btn_start ignored; on door_open=1: pulse t_pause, ->PAUSED.
  - btn_stop: pulse t_stop, clear digits, ->IDLE.
  - timer_done=1: ->BEEP, load beep counter.
  - min/sec are held stable throughout RUN.
- PAUSED:
  - btn_start with door closed: pulse t_start, ->RUN.
  - btn_stop: pulse t_stop, clear digits, ->IDLE.
  - btn_add30 and key_valid are ignored.
- BEEP:
  - buzzer=1; counter decrements each cycle. At 0 ->IDLE with digits cleared.
  - Any btn_start/btn_stop/btn_add30/key_valid, or door_open=1, cancels: ->IDLE.
- Priority of simultaneous events, per state (highest first):
  - RUN: timer_done > btn_stop > door_open.
  - IDLE/ENTRY: btn_stop > btn_start > btn_add30 > key_valid.
  - Any event not taken in a cycle is dropped.
- Reset mid-RUN: outputs return to reset values with no stop pulse issued; the timer is reset by the same reset net.

Decomposition:
- Shared package microwave_pkg:
  - state encoding (IDLE=0, ENTRY=1, RUN=2, PAUSED=3, BEEP=4, 3 bits);
  - constants SEC_LIMIT=60, MIN_MAX=99, ADD30_SEC=30;
  - BCD digit type (4 bits).
- Sub-module bcd_entry:
  - 4-digit shift register with clear/load;
  - BCD->binary conversion and normalise/saturate logic;
  - +30 s add.
- microwave_ctrl keeps the FSM, beep counter and output registers.

Test Plan:
- Keys 1,2,3,0 then btn_start, door closed -> min=12, sec=30, t_start high exactly 1 cycle after btn_start, magnetron_on=1.
- Keys 0,1,7,5, start -> loaded min=2, sec=15. Keys 9,9,9,9, start -> loaded 99:59.
- RUN, door_open=1 -> t_pause pulse, magnetron_on=0, lamp_on=1. btn_start while door open ignored. Door closed, btn_start -> t_start pulse, RUN.
- IDLE empty, btn_add30 -> min=0, sec=30, t_start pulse. Entry 99:45 +add30 -> 99:59, no start.
- RUN, timer_done=1 -> buzzer=1 for BEEP_CYCLES (override to 10), then IDLE. Second run: btn_stop during BEEP -> buzzer=0 next cycle.
- RUN with btn_stop and timer_done in the same cycle -> BEEP, no t_stop. Async reset mid-RUN -> all outputs 0 immediately.

Source files
------------

// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave controller: state encoding,
// BCD digit type, time limits and BCD/binary helpers.
package microwave_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ENTRY  = 3'd1,
    RUN    = 3'd2,
    PAUSED = 3'd3,
    BEEP   = 3'd4
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEC_LIMIT = 7'd60;
  localparam logic [6:0] MIN_MAX   = 7'd99;
  localparam logic [6:0] ADD30_SEC = 7'd30;

  function automatic logic [6:0] bcd2bin(bcd_t tens, bcd_t ones);
    return {3'b000, tens} * 7'd10 + {3'b000, ones};
  endfunction

  function automatic bcd_t tens_of(logic [6:0] v);
    return 4'(v / 7'd10);
  endfunction

  function automatic bcd_t ones_of(logic [6:0] v);
    return 4'(v % 7'd10);
  endfunction

endpackage

// File: rtl/bcd_entry.sv
// Four-digit MM:SS keypad entry register with raw/normalised binary views
// and an in-place +30 s update.
module bcd_entry
  import microwave_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       shift,
  input  logic       add30,
  input  bcd_t       digit,
  output logic [6:0] raw_min,
  output logic [6:0] raw_sec,
  output logic [6:0] norm_min,
  output logic [6:0] norm_sec,
  output logic       is_zero
);

  bcd_t d3, d2, d1, d0;
  logic [6:0] add_min, add_sec;

  always_comb begin
    raw_min  = bcd2bin(d3, d2);
    raw_sec  = bcd2bin(d1, d0);
    norm_min = raw_min;
    norm_sec = raw_sec;
    if (raw_sec >= SEC_LIMIT) begin
      norm_sec = raw_sec - SEC_LIMIT;
      norm_min = raw_min + 7'd1;
    end
    if (norm_min > MIN_MAX) begin
      norm_min = MIN_MAX;
      norm_sec = SEC_LIMIT - 7'd1;
    end

    // +30 s is applied to the normalised value, so seconds never exceed 89 here
    add_min = norm_min;
    add_sec = norm_sec + ADD30_SEC;
    if (add_sec >= SEC_LIMIT) begin
      add_sec = add_sec - SEC_LIMIT;
      add_min = norm_min + 7'd1;
    end
    if (add_min > MIN_MAX) begin
      add_min = MIN_MAX;
      add_sec = SEC_LIMIT - 7'd1;
    end

    is_zero = ({d3, d2, d1, d0} == 16'h0000);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      d3 <= '0;
      d2 <= '0;
      d1 <= '0;
      d0 <= '0;
    end else if (clear) begin
      d3 <= '0;
      d2 <= '0;
      d1 <= '0;
      d0 <= '0;
    end else if (add30) begin
      d3 <= tens_of(add_min);
      d2 <= ones_of(add_min);
      d1 <= tens_of(add_sec);
      d0 <= ones_of(add_sec);
    end else if (shift) begin
      d3 <= d2;
      d2 <= d1;
      d1 <= d0;
      d0 <= digit;
    end
  end

endmodule

// File: rtl/microwave_ctrl.sv
// Microwave sequencer: keypad entry, timer command pulses, door handling,
// beep timing and magnetron/lamp/buzzer drive.
module microwave_ctrl
  import microwave_pkg::*;
#(
  parameter int unsigned BEEP_CYCLES = 300_000_000,
  parameter int unsigned BEEP_W      = 29
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       btn_add30,
  input  logic       door_open,
  input  logic       timer_done,
  output logic [6:0] min,
  output logic [6:0] sec,
  output logic       t_start,
  output logic       t_stop,
  output logic       t_pause,
  output logic       magnetron_on,
  output logic       lamp_on,
  output logic       buzzer,
  output state_t     state_dbg
);

  state_t state, nxt;
  logic [BEEP_W-1:0] beep_cnt, cnt_n;
  logic [6:0] raw_min, raw_sec, norm_min, norm_sec, min_n, sec_n;
  logic is_zero, key_ok, lamp_q;
  logic ent_clear, ent_shift, ent_add30, load_run, add_start;
  logic start_n, stop_n, pause_n;

  bcd_entry u_entry (
    .clock    (clock),
    .reset    (reset),
    .clear    (ent_clear),
    .shift    (ent_shift),
    .add30    (ent_add30),
    .digit    (key_digit),
    .raw_min  (raw_min),
    .raw_sec  (raw_sec),
    .norm_min (norm_min),
    .norm_sec (norm_sec),
    .is_zero  (is_zero)
  );

  assign key_ok    = key_valid && (key_digit <= 4'd9);
  assign lamp_on   = lamp_q | door_open;
  assign state_dbg = state;

  always_comb begin
    nxt       = state;
    cnt_n     = beep_cnt;
    ent_clear = 1'b0;
    ent_shift = 1'b0;
    ent_add30 = 1'b0;
    load_run  = 1'b0;
    add_start = 1'b0;
    start_n   = 1'b0;
    stop_n    = 1'b0;
    pause_n   = 1'b0;
    case (state)
      IDLE, ENTRY: begin
        if (btn_stop) begin
          ent_clear = 1'b1;
          nxt       = IDLE;
        end else if (btn_start) begin
          if (!door_open && !is_zero) begin
            load_run = 1'b1;
            start_n  = 1'b1;
            nxt      = RUN;
          end
        end else if (btn_add30) begin
          ent_add30 = 1'b1;
          if (state == IDLE && is_zero && !door_open) begin
            add_start = 1'b1;
            start_n   = 1'b1;
            nxt       = RUN;
          end else begin
            nxt = ENTRY;
          end
        end else if (key_ok) begin
          ent_shift = 1'b1;
          nxt       = ENTRY;
        end
      end
      RUN: begin
        if (timer_done) begin
          nxt   = BEEP;
          cnt_n = BEEP_W'(BEEP_CYCLES - 1);
        end else if (btn_stop) begin
          stop_n    = 1'b1;
          ent_clear = 1'b1;
          nxt       = IDLE;
        end else if (door_open) begin
          pause_n = 1'b1;
          nxt     = PAUSED;
        end
      end
      PAUSED: begin
        if (btn_stop) begin
          stop_n    = 1'b1;
          ent_clear = 1'b1;
          nxt       = IDLE;
        end else if (btn_start && !door_open) begin
          start_n = 1'b1;
          nxt     = RUN;
        end
      end
      BEEP: begin
        if (btn_start || btn_stop || btn_add30 || key_valid || door_open || beep_cnt == '0) begin
          ent_clear = 1'b1;
          cnt_n     = '0;
          nxt       = IDLE;
        end else begin
          cnt_n = beep_cnt - 1'b1;
        end
      end
      default: begin
        ent_clear = 1'b1;
        nxt       = IDLE;
      end
    endcase

    // Display tracks the raw entry while editing, and is frozen once timing starts
    min_n = min;
    sec_n = sec;
    if (load_run) begin
      min_n = norm_min;
      sec_n = norm_sec;
    end else if (add_start) begin
      min_n = 7'd0;
      sec_n = ADD30_SEC;
    end else if ((state == IDLE || state == ENTRY) && (nxt == IDLE || nxt == ENTRY)) begin
      min_n = raw_min;
      sec_n = raw_sec;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      beep_cnt     <= '0;
      min          <= '0;
      sec          <= '0;
      t_start      <= 1'b0;
      t_stop       <= 1'b0;
      t_pause      <= 1'b0;
      magnetron_on <= 1'b0;
      buzzer       <= 1'b0;
      lamp_q       <= 1'b0;
    end else begin
      state        <= nxt;
      beep_cnt     <= cnt_n;
      min          <= min_n;
      sec          <= sec_n;
      t_start      <= start_n;
      t_stop       <= stop_n;
      t_pause      <= pause_n;
      magnetron_on <= (nxt == RUN);
      buzzer       <= (nxt == BEEP);
      lamp_q       <= (nxt == RUN) || (nxt == PAUSED);
    end
  end

endmodule
